// File: rtl/bayer_wb_gain_if.sv
// Raw pixel stream into the white-balance gain stage and the scaled stream out of it.
interface bayer_wb_gain_if #(
    parameter int DATA_W = 16
);
    logic              data_en;
    logic [DATA_W-1:0] isp_data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_out_en;

    modport master (output data_en, output isp_data_in, input data_out, input data_out_en);
    modport slave  (input data_en, input isp_data_in, output data_out, output data_out_en);
endinterface

// File: rtl/bayer_wb_gain.sv
// Per-channel Bayer white-balance gain: phase tracking, per-frame gain shadowing, round/saturate.
// Define WB_STATS_EN to build the per-frame R / G / B raw pixel statistics accumulators.
module bayer_wb_gain #(
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 6,
    parameter int DIM_W     = 12
) (
    input  logic                isp_clk,
    input  logic                rst,
    bayer_wb_gain_if.slave      pix,
    input  logic [DIM_W-1:0]    h_active_in,
    input  logic [DIM_W-1:0]    v_active_in,
    input  logic [3:0]          bayerStart,
    input  logic [GAIN_W-1:0]   r_gain,
    input  logic [GAIN_W-1:0]   gr_gain,
    input  logic [GAIN_W-1:0]   gb_gain,
    input  logic [GAIN_W-1:0]   b_gain,
    input  logic                bypass,
    output logic                line_err,
    output logic                frame_done,
    output logic [15:0]         frames_cnt,
    output logic [DATA_W+23:0]  r_sum,
    output logic [DATA_W+23:0]  g_sum,
    output logic [DATA_W+23:0]  b_sum,
    output logic                stats_valid
);
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic [GAIN_W-1:0] UNITY_GAIN = GAIN_W'(1'b1) << GAIN_FRAC;
    localparam logic [SUM_W-1:0]  ROUND_HALF = SUM_W'(1'b1) << (GAIN_FRAC - 1);

    logic                de_prev_r;
    logic                rise_s, fall_s, frame_end_s, load_s;
    logic [DIM_W-1:0]    col_r, row_r, col_idx_s;
    logic [GAIN_W-1:0]   sh_r_gain_r, sh_gr_gain_r, sh_gb_gain_r, sh_b_gain_r;
    logic                sh_bypass_r;
    logic [1:0]          phase_s, chan_s;
    logic [GAIN_W-1:0]   gain_s;
    logic                bypass_s;
    logic                s1_en_r, s1_bypass_r;
    logic [DATA_W-1:0]   s1_raw_r;
    logic [PROD_W-1:0]   s1_prod_r;
    logic [SUM_W-1:0]    rounded_s, q_s;
    logic [DATA_W-1:0]   result_s;
    logic                frame_end_r;

    // Line framing, pixel position and channel/gain selection for the pixel on the input
    always_comb begin
        rise_s      = pix.data_en & ~de_prev_r;
        fall_s      = ~pix.data_en & de_prev_r;
        frame_end_s = fall_s && (row_r == (v_active_in - DIM_W'(1'b1)));
        load_s      = rise_s && (row_r == {DIM_W{1'b0}});
        if (rise_s) begin
            col_idx_s = {DIM_W{1'b0}};
        end else begin
            col_idx_s = col_r;
        end
        case (bayerStart)
            4'b0010: phase_s = 2'd1;
            4'b0100: phase_s = 2'd2;
            4'b1000: phase_s = 2'd3;
            default: phase_s = 2'd0;
        endcase
        chan_s = phase_s ^ {row_r[0], col_idx_s[0]};
        // The first pixel of a frame already uses the gains being latched on that edge
        case (chan_s)
            2'd0:    gain_s = load_s ? r_gain  : sh_r_gain_r;
            2'd1:    gain_s = load_s ? gr_gain : sh_gr_gain_r;
            2'd2:    gain_s = load_s ? gb_gain : sh_gb_gain_r;
            default: gain_s = load_s ? b_gain  : sh_b_gain_r;
        endcase
        if (load_s) begin
            bypass_s = bypass;
        end else begin
            bypass_s = sh_bypass_r;
        end
    end

    // Column/row counters, gain shadows, line error and frame completion
    always_ff @(posedge isp_clk or posedge rst) begin
        if (rst) begin
            de_prev_r    <= 1'b0;
            col_r        <= {DIM_W{1'b0}};
            row_r        <= {DIM_W{1'b0}};
            sh_r_gain_r  <= UNITY_GAIN;
            sh_gr_gain_r <= UNITY_GAIN;
            sh_gb_gain_r <= UNITY_GAIN;
            sh_b_gain_r  <= UNITY_GAIN;
            sh_bypass_r  <= 1'b0;
            line_err     <= 1'b0;
            frame_end_r  <= 1'b0;
            frame_done   <= 1'b0;
            frames_cnt   <= 16'd0;
        end else begin
            de_prev_r <= pix.data_en;
            if (pix.data_en) begin
                col_r <= col_idx_s + DIM_W'(1'b1);
            end
            if (fall_s) begin
                row_r <= frame_end_s ? {DIM_W{1'b0}} : (row_r + DIM_W'(1'b1));
            end
            if (load_s) begin
                sh_r_gain_r  <= r_gain;
                sh_gr_gain_r <= gr_gain;
                sh_gb_gain_r <= gb_gain;
                sh_b_gain_r  <= b_gain;
                sh_bypass_r  <= bypass;
            end
            line_err    <= fall_s && (col_r != h_active_in);
            // Two-stage delay lines frame_done up with the drain of the last output pixel
            frame_end_r <= frame_end_s;
            frame_done  <= frame_end_r;
            if (frame_end_r) begin
                frames_cnt <= frames_cnt + 16'd1;
            end
        end
    end

    // Stage 2 combinational part: round half up, then saturate to the pixel range
    always_comb begin
        rounded_s = {1'b0, s1_prod_r} + ROUND_HALF;
        q_s       = rounded_s >> GAIN_FRAC;
        if (s1_bypass_r) begin
            result_s = s1_raw_r;
        end else if (|q_s[SUM_W-1:DATA_W]) begin
            result_s = {DATA_W{1'b1}};
        end else begin
            result_s = q_s[DATA_W-1:0];
        end
    end

    // Pipeline registers: stage 1 multiply, stage 2 rounded result
    always_ff @(posedge isp_clk or posedge rst) begin
        if (rst) begin
            s1_en_r         <= 1'b0;
            s1_bypass_r     <= 1'b0;
            s1_raw_r        <= {DATA_W{1'b0}};
            s1_prod_r       <= {PROD_W{1'b0}};
            pix.data_out_en <= 1'b0;
            pix.data_out    <= {DATA_W{1'b0}};
        end else begin
            s1_en_r         <= pix.data_en;
            s1_bypass_r     <= bypass_s;
            s1_raw_r        <= pix.isp_data_in;
            s1_prod_r       <= PROD_W'(pix.isp_data_in) * PROD_W'(gain_s);
            pix.data_out_en <= s1_en_r;
            pix.data_out    <= result_s;
        end
    end

`ifdef WB_STATS_EN
    logic [DATA_W+23:0] acc_r_r, acc_g_r, acc_b_r;
    logic [DATA_W+23:0] add_r_s, add_g_s, add_b_s;

    // Route the raw input pixel to its channel's accumulator (Gr and Gb share G)
    always_comb begin
        add_r_s = {(DATA_W+24){1'b0}};
        add_g_s = {(DATA_W+24){1'b0}};
        add_b_s = {(DATA_W+24){1'b0}};
        if (pix.data_en) begin
            case (chan_s)
                2'd0:       add_r_s = (DATA_W+24)'(pix.isp_data_in);
                2'd1, 2'd2: add_g_s = (DATA_W+24)'(pix.isp_data_in);
                default:    add_b_s = (DATA_W+24)'(pix.isp_data_in);
            endcase
        end else begin
            add_r_s = {(DATA_W+24){1'b0}};
        end
    end

    // Publish and restart the sums at frame end; a pixel on that edge opens the next frame
    always_ff @(posedge isp_clk or posedge rst) begin
        if (rst) begin
            acc_r_r     <= {(DATA_W+24){1'b0}};
            acc_g_r     <= {(DATA_W+24){1'b0}};
            acc_b_r     <= {(DATA_W+24){1'b0}};
            r_sum       <= {(DATA_W+24){1'b0}};
            g_sum       <= {(DATA_W+24){1'b0}};
            b_sum       <= {(DATA_W+24){1'b0}};
            stats_valid <= 1'b0;
        end else if (frame_end_r) begin
            r_sum       <= acc_r_r;
            g_sum       <= acc_g_r;
            b_sum       <= acc_b_r;
            acc_r_r     <= add_r_s;
            acc_g_r     <= add_g_s;
            acc_b_r     <= add_b_s;
            stats_valid <= 1'b1;
        end else begin
            acc_r_r     <= acc_r_r + add_r_s;
            acc_g_r     <= acc_g_r + add_g_s;
            acc_b_r     <= acc_b_r + add_b_s;
            stats_valid <= 1'b0;
        end
    end
`else
    assign r_sum       = {(DATA_W+24){1'b0}};
    assign g_sum       = {(DATA_W+24){1'b0}};
    assign b_sum       = {(DATA_W+24){1'b0}};
    assign stats_valid = 1'b0;
`endif
endmodule

// File: tb/tb_bayer_wb_gain.sv
// Self-checking bench for bayer_wb_gain: random pixels against a behavioural Bayer gain model.
module tb_bayer_wb_gain;
    localparam int DATA_W = 16, GAIN_W = 8, GAIN_FRAC = 6, DIM_W = 12;

    logic              isp_clk = 1'b0;
    logic              rst;
    logic [DIM_W-1:0]  h_active_in, v_active_in;
    logic [3:0]        bayerStart;
    logic [7:0]        r_gain, gr_gain, gb_gain, b_gain;
    logic              bypass, line_err, frame_done, stats_valid;
    logic [15:0]       frames_cnt;
    logic [39:0]       r_sum, g_sum, b_sum;

    bayer_wb_gain_if #(.DATA_W(DATA_W)) bus ();

    bayer_wb_gain #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC), .DIM_W(DIM_W)) dut (
        .isp_clk(isp_clk), .rst(rst), .pix(bus),
        .h_active_in(h_active_in), .v_active_in(v_active_in), .bayerStart(bayerStart),
        .r_gain(r_gain), .gr_gain(gr_gain), .gb_gain(gb_gain), .b_gain(b_gain),
        .bypass(bypass), .line_err(line_err), .frame_done(frame_done), .frames_cnt(frames_cnt),
        .r_sum(r_sum), .g_sum(g_sum), .b_sum(b_sum), .stats_valid(stats_valid)
    );

    always #5 isp_clk = ~isp_clk;

    int checks = 0, errors = 0;
    // output collector (written only by the negedge process)
    logic [15:0] got_mem [4096];
    int          got_n, le_cnt, fd_cnt, sv_cnt;
    logic        prev_en, fd_aligned, le_aligned;
    logic [39:0] got_rs, got_gs, got_bs;
    // reference model state
    int          m_row, m_frames, m_le, rd;
    int          m_gain [4];
    bit          m_byp;
    longint      m_acc [3];
    longint      m_sum [3];
    logic [15:0] lp [64];
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;

    always @(negedge isp_clk) begin
        if (rst) begin
            got_n <= 0; le_cnt <= 0; fd_cnt <= 0; sv_cnt <= 0;
            prev_en <= 1'b0; fd_aligned <= 1'b0; le_aligned <= 1'b0;
        end else begin
            prev_en <= bus.data_out_en;
            if (bus.data_out_en && got_n < 4096) begin
                got_mem[got_n] <= bus.data_out;
                got_n <= got_n + 1;
            end
            if (frame_done) begin
                fd_cnt <= fd_cnt + 1;
                fd_aligned <= !bus.data_out_en && prev_en;
            end
            if (line_err) begin
                le_cnt <= le_cnt + 1;
                le_aligned <= bus.data_out_en;
            end
            if (stats_valid) begin
                sv_cnt <= sv_cnt + 1;
                got_rs <= r_sum; got_gs <= g_sum; got_bs <= b_sum;
            end
        end
    end

    // Colour at (row, col) read from the mosaic's 2x2 tile: R, G (red row), g (blue row), B
    function automatic int chan_at(logic [3:0] bs, int r, int c);
        string pat;
        byte   ch;
        case (bs)
            4'b0010: pat = "GRBg";
            4'b0100: pat = "gBRG";
            4'b1000: pat = "BgGR";
            default: pat = "RGgB";
        endcase
        ch = pat[(r % 2) * 2 + (c % 2)];
        if (ch == "R") return 0;
        else if (ch == "G") return 1;
        else if (ch == "g") return 2;
        else return 3;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        rd = 0; m_row = 0; m_frames = 0; m_le = 0; m_byp = 1'b0;
        m_gain = '{64, 64, 64, 64};
        m_acc = '{0, 0, 0};
        m_sum = '{0, 0, 0};
    endtask

    task automatic do_reset();
        @(posedge isp_clk); #1;
        rst = 1'b1; bus.data_en = 1'b0; bus.isp_data_in = 16'h0000;
        @(posedge isp_clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        repeat (5) @(posedge isp_clk);
        #1;
    endtask

    // Drives lp[0..n-1] as one line, then gap idle cycles, updating the model
    task automatic drive_line(input int n, input int gap);
        int ch, p;
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge isp_clk); #1;
            if (i == 0 && m_row == 0) begin
                m_gain = '{int'(r_gain), int'(gr_gain), int'(gb_gain), int'(b_gain)};
                m_byp = bypass;
            end
            ch = chan_at(bayerStart, m_row, i);
            bus.data_en = 1'b1;
            bus.isp_data_in = lp[i];
            p = (int'(lp[i]) * m_gain[ch] + (1 << (GAIN_FRAC - 1))) / (1 << GAIN_FRAC);
            if (m_byp) e = lp[i];
            else if (p > 65535) e = 16'hFFFF;
            else e = 16'(p);
            exp_q.push_back(e);
            m_acc[(ch == 0) ? 0 : ((ch == 3) ? 2 : 1)] += longint'(lp[i]);
        end
        @(posedge isp_clk); #1;
        bus.data_en = 1'b0;
        if (n != int'(h_active_in)) m_le++;
        if (m_row == int'(v_active_in) - 1) begin
            m_row = 0; m_frames++; m_sum = m_acc; m_acc = '{0, 0, 0};
        end else begin
            m_row++;
        end
        repeat (gap - 1) @(posedge isp_clk);
    endtask

    task automatic set_unity();
        r_gain = 8'h40; gr_gain = 8'h40; gb_gain = 8'h40; b_gain = 8'h40; bypass = 1'b0;
        bayerStart = 4'b0001; h_active_in = 12'd16; v_active_in = 12'd32;
    endtask

    task automatic test_reset();
        @(posedge isp_clk); #1;
        rst = 1'b1;
        @(negedge isp_clk);
        checks++;
        if (bus.data_out !== 16'h0000 || bus.data_out_en !== 1'b0 || line_err !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_out: out=%h en=%b le=%b fd=%b, required all 0", bus.data_out, bus.data_out_en, line_err, frame_done);
        end
        checks++;
        if (frames_cnt !== 16'd0 || r_sum !== 40'd0 || g_sum !== 40'd0 || b_sum !== 40'd0 || stats_valid !== 1'b0) begin
            errors++; $display("FAIL reset_cnt: frames=%0d r=%0d g=%0d b=%0d sv=%b, required 0", frames_cnt, r_sum, g_sum, b_sum, stats_valid);
        end
        @(posedge isp_clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_unity();
        set_unity();
        do_reset();
        @(posedge isp_clk); #1;
        bus.data_en = 1'b1; bus.isp_data_in = 16'h1230;
        @(posedge isp_clk); #1;
        bus.data_en = 1'b0;
        @(negedge isp_clk);
        checks++;
        if (bus.data_out_en !== 1'b0) begin errors++; $display("FAIL unity_lat1: en=%b required 0", bus.data_out_en); end
        @(negedge isp_clk);
        checks++;
        if (bus.data_out_en !== 1'b1 || bus.data_out !== 16'h1230) begin
            errors++; $display("FAIL unity_lat2: en=%b out=%h required 1 1230", bus.data_out_en, bus.data_out);
        end
        @(negedge isp_clk);
        checks++;
        if (bus.data_out_en !== 1'b0) begin errors++; $display("FAIL unity_lat3: en=%b required 0", bus.data_out_en); end
    endtask

    task automatic test_phase(input logic [3:0] bs, input logic [15:0] e00, input logic [15:0] e01,
                              input logic [15:0] e10, input logic [15:0] e11);
        set_unity();
        r_gain = 8'h40; gr_gain = 8'h80; gb_gain = 8'h20; b_gain = 8'h60; bayerStart = bs;
        do_reset();
        for (int i = 0; i < 16; i++) lp[i] = 16'h0100;
        drive_line(16, 4);
        drive_line(16, 4);
        drain();
        checks++;
        if (got_mem[0] !== e00 || got_mem[1] !== e01 || got_mem[16] !== e10 || got_mem[17] !== e11) begin
            errors++; $display("FAIL phase_%b: %h %h / %h %h required %h %h / %h %h", bs,
                got_mem[0], got_mem[1], got_mem[16], got_mem[17], e00, e01, e10, e11);
        end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rd >= got_n) begin errors++; $display("FAIL phase_pix: no output, required %h", exp_v); end
            else begin
                if (got_mem[rd] !== exp_v) begin errors++; $display("FAIL phase_pix[%0d]: got %h required %h", rd, got_mem[rd], exp_v); end
                rd++;
            end
        end
    endtask

    task automatic test_round_sat();
        set_unity();
        r_gain = 8'h60; gr_gain = 8'h80;
        do_reset();
        lp[0] = 16'h0011; lp[1] = 16'hFFF0;
        drive_line(2, 4);
        drain();
        checks++;
        if (got_mem[0] !== 16'h001A) begin errors++; $display("FAIL round: got %h required 001a", got_mem[0]); end
        checks++;
        if (got_mem[1] !== 16'hFFFF) begin errors++; $display("FAIL saturate: got %h required ffff", got_mem[1]); end
        bypass = 1'b1;
        do_reset();
        lp[0] = 16'hFFF0;
        drive_line(1, 4);
        drain();
        checks++;
        if (got_n != 1 || got_mem[0] !== 16'hFFF0) begin errors++; $display("FAIL bypass: got %h (n=%0d) required fff0", got_mem[0], got_n); end
        bypass = 1'b0;
    endtask

    task automatic test_framing();
        set_unity();
        do_reset();
        for (int l = 0; l < 32; l++) begin
            for (int i = 0; i < 16; i++) lp[i] = 16'($urandom);
            drive_line(16, 2);
        end
        drain();
        checks++;
        if (fd_cnt != 1 || frames_cnt !== 16'd1) begin errors++; $display("FAIL frame_done: pulses=%0d frames=%0d required 1 1", fd_cnt, frames_cnt); end
        checks++;
        if (fd_aligned !== 1'b1) begin errors++; $display("FAIL frame_done_timing: aligned=%b required 1", fd_aligned); end
        checks++;
        if (le_cnt != 0) begin errors++; $display("FAIL no_line_err: pulses=%0d required 0", le_cnt); end
`ifdef WB_STATS_EN
        checks++;
        if (sv_cnt != 1 || got_rs !== 40'(m_sum[0]) || got_gs !== 40'(m_sum[1]) || got_bs !== 40'(m_sum[2])) begin
            errors++; $display("FAIL stats: n=%0d r=%0d g=%0d b=%0d required 1 %0d %0d %0d", sv_cnt, got_rs, got_gs, got_bs, m_sum[0], m_sum[1], m_sum[2]);
        end
`else
        checks++;
        if (sv_cnt != 0 || r_sum !== 40'd0 || g_sum !== 40'd0 || b_sum !== 40'd0) begin
            errors++; $display("FAIL stats_off: n=%0d r=%0d required 0 0", sv_cnt, r_sum);
        end
`endif
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rd >= got_n) begin errors++; $display("FAIL frame_pix: no output, required %h", exp_v); end
            else begin
                if (got_mem[rd] !== exp_v) begin errors++; $display("FAIL frame_pix[%0d]: got %h required %h", rd, got_mem[rd], exp_v); end
                rd++;
            end
        end
        for (int i = 0; i < 20; i++) lp[i] = 16'($urandom);
        drive_line(20, 2);
        drain();
        checks++;
        if (le_cnt != 1 || le_aligned !== 1'b1) begin errors++; $display("FAIL line_err: pulses=%0d aligned=%b required 1 1", le_cnt, le_aligned); end
    endtask

    task automatic test_shadow();
        set_unity();
        do_reset();
        for (int i = 0; i < 16; i++) lp[i] = 16'h0100;
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 32; l++) begin
                if (f == 0 && l == 5) r_gain = 8'h80;
                drive_line(16, 2);
            end
        end
        drain();
        checks++;
        if (got_mem[0] !== 16'h0100 || got_mem[96] !== 16'h0100) begin
            errors++; $display("FAIL shadow_hold: row0 %h row6 %h required 0100 0100", got_mem[0], got_mem[96]);
        end
        checks++;
        if (got_mem[512] !== 16'h0200) begin errors++; $display("FAIL shadow_next: got %h required 0200", got_mem[512]); end
`ifdef WB_STATS_EN
        checks++;
        if (got_rs !== 40'd32768) begin errors++; $display("FAIL shadow_rsum: got %0d required 32768", got_rs); end
`endif
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rd >= got_n) begin errors++; $display("FAIL shadow_pix: no output, required %h", exp_v); end
            else begin
                if (got_mem[rd] !== exp_v) begin errors++; $display("FAIL shadow_pix[%0d]: got %h required %h", rd, got_mem[rd], exp_v); end
                rd++;
            end
        end
        r_gain = 8'h40;
    endtask

    task automatic test_rst_mid();
        set_unity();
        do_reset();
        for (int l = 0; l < 7; l++) begin
            for (int i = 0; i < 16; i++) lp[i] = 16'($urandom);
            drive_line(16, 2);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge isp_clk); #1;
            bus.data_en = 1'b1; bus.isp_data_in = 16'($urandom_range(1, 65535));
        end
        @(posedge isp_clk); #1;
        rst = 1'b1;
        @(negedge isp_clk);
        checks++;
        if (bus.data_out !== 16'h0000 || bus.data_out_en !== 1'b0 || line_err !== 1'b0 || frame_done !== 1'b0 || frames_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid: out=%h en=%b le=%b fd=%b frames=%0d required 0", bus.data_out, bus.data_out_en, line_err, frame_done, frames_cnt);
        end
        @(posedge isp_clk); #1;
        rst = 1'b0; bus.data_en = 1'b0;
        model_clear();
        for (int l = 0; l < 32; l++) begin
            for (int i = 0; i < 16; i++) lp[i] = 16'($urandom);
            if (l == 31) begin
                checks++;
                if (frames_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt0: frames=%0d required 0", frames_cnt); end
            end
            drive_line(16, 2);
        end
        drain();
        checks++;
        if (frames_cnt !== 16'd1 || fd_cnt != 1) begin errors++; $display("FAIL rst_mid_cnt1: frames=%0d pulses=%0d required 1 1", frames_cnt, fd_cnt); end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rd >= got_n) begin errors++; $display("FAIL rst_pix: no output, required %h", exp_v); end
            else begin
                if (got_mem[rd] !== exp_v) begin errors++; $display("FAIL rst_pix[%0d]: got %h required %h", rd, got_mem[rd], exp_v); end
                rd++;
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] bs_tab [5];
        bs_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110};
        set_unity();
        h_active_in = 12'($urandom_range(4, 20));
        v_active_in = 12'($urandom_range(2, 5));
        do_reset();
        for (int f = 0; f < 4; f++) begin
            bayerStart = bs_tab[$urandom_range(0, 4)];
            for (int l = 0; l < int'(v_active_in); l++) begin
                r_gain = 8'($urandom); gr_gain = 8'($urandom); gb_gain = 8'($urandom); b_gain = 8'($urandom);
                bypass = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < 24; i++) lp[i] = 16'($urandom);
                drive_line(($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : int'(h_active_in), $urandom_range(1, 3));
            end
        end
        drain();
        checks++;
        if (le_cnt != m_le) begin errors++; $display("FAIL rand_line_err: pulses=%0d required %0d", le_cnt, m_le); end
        checks++;
        if (fd_cnt != m_frames || frames_cnt !== 16'(m_frames)) begin
            errors++; $display("FAIL rand_frames: pulses=%0d cnt=%0d required %0d", fd_cnt, frames_cnt, m_frames);
        end
`ifdef WB_STATS_EN
        checks++;
        if (got_rs !== 40'(m_sum[0]) || got_gs !== 40'(m_sum[1]) || got_bs !== 40'(m_sum[2])) begin
            errors++; $display("FAIL rand_stats: r=%0d g=%0d b=%0d required %0d %0d %0d", got_rs, got_gs, got_bs, m_sum[0], m_sum[1], m_sum[2]);
        end
`endif
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rd >= got_n) begin errors++; $display("FAIL rand_pix: no output, required %h", exp_v); end
            else begin
                if (got_mem[rd] !== exp_v) begin errors++; $display("FAIL rand_pix[%0d]: got %h required %h", rd, got_mem[rd], exp_v); end
                rd++;
            end
        end
        checks++;
        if (got_n != rd) begin errors++; $display("FAIL rand_extra: outputs=%0d required %0d", got_n, rd); end
        bypass = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.data_en = 1'b0;
        bus.isp_data_in = 16'h0000;
        set_unity();
        model_clear();
        repeat (2) @(posedge isp_clk);
        test_reset();
        test_unity();
        test_phase(4'b0001, 16'h0100, 16'h0200, 16'h0080, 16'h0180);
        test_phase(4'b1000, 16'h0180, 16'h0080, 16'h0200, 16'h0100);
        test_round_sat();
        test_framing();
        test_shadow();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
